// File: rtl/tdc_multihit_core.sv
// Multi-hit TDC core: timestamps SPAD triggers against a coarse counter plus DLL phase edge,
// buffers up to MAX_HITS per frame and drains them over an AXI-stream style handshake.
//
// state | meaning
// IDLE  | waiting for TDC_start
// ARMED | window open, coarse counting, hits captured
// DRAIN | window closed, buffered hits streamed out
module tdc_multihit_core #(
    parameter int NPHASE       = 32,
    parameter int COARSE_W     = 10,
    parameter int MAX_HITS     = 4,
    parameter int NSPAD        = 16,
    parameter int STOP_ON_FULL = 0,
    localparam int FINE_W = $clog2(NPHASE),
    localparam int DATA_W = COARSE_W + FINE_W,
    localparam int NUM_W  = $clog2(MAX_HITS + 1),
    localparam int INT_W  = $clog2(NSPAD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                TDC_start,
    input  logic                TDC_trigger,
    input  logic [NPHASE-1:0]   DLL_Phase,
    input  logic [NSPAD-1:0]    TDC_spaden,
    input  logic [COARSE_W-1:0] TDC_Range,
    output logic [DATA_W-1:0]   TDC_Odata,
    output logic [INT_W-1:0]    TDC_Oint,
    output logic [NUM_W-1:0]    TDC_Onum,
    output logic                TDC_Oovf,
    output logic                TDC_Olast,
    output logic                TDC_Ovalid,
    input  logic                TDC_Oready,
    output logic                rst_auto,
    output logic                busy
);

    // Buffer is sized to the full index range so count/rd_ptr address it without truncation.
    localparam int BUF_D = 1 << NUM_W;
    localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_HITS);
    localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);
    localparam bit STOP_EN = (STOP_ON_FULL != 0);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

    state_t state, state_nxt;

    logic [COARSE_W-1:0] coarse;
    logic [NUM_W-1:0]    count;
    logic [NUM_W-1:0]    rd_ptr;
    logic                ovf;
    logic [DATA_W-1:0]   data_buf [BUF_D];
    logic [INT_W-1:0]    int_buf  [BUF_D];

    logic [NPHASE-1:0] edges;
    logic [FINE_W-1:0] fine;
    logic [INT_W-1:0]  hit_int;
    logic              bubble;
    logic              accept;
    logic              store;
    logic              close_win;
    logic              handshake;
    logic              last_beat;

    // Rising edge around the phase ring: tap high while its predecessor (mod NPHASE) is low.
    assign edges  = DLL_Phase & ~{DLL_Phase[NPHASE-2:0], DLL_Phase[NPHASE-1]};
    assign bubble = (edges == '0);

    always_comb begin
        fine = '0;
        for (int i = NPHASE - 1; i >= 0; i--) begin
            if (edges[i]) fine = FINE_W'(i);
        end
    end

    always_comb begin
        hit_int = '0;
        for (int i = 0; i < NSPAD; i++) begin
            hit_int = hit_int + INT_W'(TDC_spaden[i]);
        end
    end

    assign accept    = (state == ARMED) && TDC_trigger;
    assign store     = accept && (count < MAX_N);
    // >= rather than == also stops the coarse counter from ever wrapping.
    assign close_win = (coarse >= TDC_Range) || (STOP_EN && store && (count == MAX_N - ONE_N));
    assign handshake = TDC_Ovalid && TDC_Oready;
    assign last_beat = (count == '0) || (rd_ptr == count - ONE_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (TDC_start) state_nxt = ARMED;
            ARMED:   if (close_win) state_nxt = DRAIN;
            DRAIN:   if (handshake && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse     <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            ovf        <= 1'b0;
            TDC_Ovalid <= 1'b0;
            rst_auto   <= 1'b0;
        end else begin
            rst_auto <= accept;
            case (state)
                IDLE: begin
                    if (TDC_start) begin
                        coarse <= '0;
                        count  <= '0;
                        rd_ptr <= '0;
                        ovf    <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!close_win) coarse <= coarse + COARSE_W'(1);
                    if (store) begin
                        count <= count + ONE_N;
                        if (bubble) ovf <= 1'b1;
                    end else if (accept) begin
                        ovf <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!TDC_Ovalid) begin
                        TDC_Ovalid <= 1'b1;
                    end else if (handshake) begin
                        if (last_beat) TDC_Ovalid <= 1'b0;
                        else           rd_ptr <= rd_ptr + ONE_N;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hit storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (store) begin
            data_buf[count] <= {coarse, fine};
            int_buf[count]  <= hit_int;
        end
    end

    assign busy      = (state != IDLE);
    assign TDC_Olast = TDC_Ovalid && last_beat;
    assign TDC_Odata = !TDC_Ovalid ? '0 : (count == '0) ? '1 : data_buf[rd_ptr];
    assign TDC_Oint  = (TDC_Ovalid && (count != '0)) ? int_buf[rd_ptr] : '0;
    assign TDC_Onum  = TDC_Ovalid ? count : '0;
    assign TDC_Oovf  = TDC_Ovalid && ovf;

endmodule
